fetch_unit: RTL
===============

# fetch_unit

Fetch stage sitting directly upstream of the fetch/decode pipeline register. It owns the PC and issues one instruction-memory request at a time over a valid/ready request channel with a variable-latency response. It presents each returned instruction, with its PC and PC+4, to the decode stage, and handles decode stalls and control-flow redirects. In-flight fetches that a redirect makes stale are dropped and never presented.

## Interface
- DATA_WIDTH, 32: width of PC, address and instruction.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-low.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_addr  output  DATA_WIDTH  fetch address; equals the current PC.
- imem_rsp_valid  input  1  response data valid; at most one response per accepted request.
- imem_rsp_data  input  DATA_WIDTH  returned instruction.
- D_stall  input  1  decode cannot accept an instruction this cycle.
- redirect  input  1  branch, jump or trap: refetch from redirect_pc.
- redirect_pc  input  DATA_WIDTH  redirect target.
- F_valid  output  1  F_instr, F_pc_out and F_pc_out4 hold a valid instruction.
- F_instr  output  DATA_WIDTH  fetched instruction.
- F_pc_out  output  DATA_WIDTH  address of F_instr.
- F_pc_out4  output  DATA_WIDTH  F_pc_out + 4.
- F_misalign  output  1  present only with FETCH_MISALIGN_CHK_EN (see Configuration).

## Operation
- `pc` is the address of the next fetch. It is updated only by a response capture (pc+4) or a redirect (redirect_pc).
- PC arithmetic is modulo 2^DATA_WIDTH, so 32'hFFFF_FFFC + 4 = 0.
- FSM states: REQ, WAIT, HOLD, DROP.
- REQ:
  - imem_req_valid = 1 and imem_addr = pc.
  - Ready without redirect: go to WAIT.
  - Redirect without ready: pc <= redirect_pc and stay in REQ. The memory does not require the address to stay stable while the request is unaccepted.
  - Redirect with ready: the old request was accepted, so pc <= redirect_pc and go to DROP.
- WAIT:
  - imem_req_valid = 0.
  - rsp_valid without redirect: F_instr <= rsp_data, F_pc_out <= pc, F_pc_out4 <= pc+4, pc <= pc+4, then go to HOLD.
  - Redirect without rsp_valid: pc <= redirect_pc, go to DROP.
  - Redirect with rsp_valid: discard the data, pc <= redirect_pc, go to REQ.
- HOLD:
  - F_valid = 1.
  - Redirect: discard the held instruction, pc <= redirect_pc, go to REQ. Redirect takes priority over consumption.
  - Otherwise, !D_stall means the instruction is consumed: go to REQ.
  - Otherwise (stalled), hold all F_* outputs unchanged.
- DROP:
  - Waits for the stale response.
  - rsp_valid: discard the data, go to REQ.
  - Redirect: pc <= redirect_pc and stay in DROP. Redirects never cancel the outstanding response.
- F_valid is 1 only in HOLD, so the F_* outputs are registered.
- A stale response is never visible on F_instr.
- A response arriving in REQ or HOLD is a protocol violation. The design ignores it.

## Timing
- Reset asserted:
  - state = REQ, pc = RESET_PC.
  - F_instr, F_pc_out, F_pc_out4 and F_valid are all 0.
  - imem_req_valid is forced to 0 while rst is low. F_misalign is 0.
- First cycle after rst deasserts: imem_req_valid = 1 with imem_addr = RESET_PC.
- Latency with zero-wait memory (ready and rsp_valid in consecutive cycles):
  - request cycle, then response cycle, then F_valid on the following edge.
  - Throughput is at most one instruction per 3 cycles.
- Redirect to the first request at the new target:
  - from REQ, WAIT-with-response or HOLD: next cycle;
  - from WAIT without a response or from DROP: the cycle after the stale response.
- Reset asserted mid-transaction abandons any outstanding request. The memory is reset on the same rst.

## Configuration
- FETCH_MISALIGN_CHK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 does not fetch. The FSM goes to HOLD with F_valid = 1, F_misalign = 1, F_instr = 32'h0000_0013 (NOP), F_pc_out = redirect_pc, F_pc_out4 = redirect_pc+4.
  - F_misalign clears when that entry is consumed or redirected. Decode raises the trap.
  - If a request is outstanding, the FSM passes through DROP first. The misaligned target is remembered and presented once the stale response arrives.
- Undefined: there is no F_misalign port. redirect_pc[1:0] is ignored, and imem_addr[1:0] is forced to 0.

## Structure
- Shared package fetch_pkg holds:
  - fetch_state_t (enum: REQ, WAIT, HOLD, DROP);
  - localparam NOP_INSTR = 32'h0000_0013;
  - localparam PC_STEP = 4.
- No sub-module; a single always_ff block and a single combinational next-state block.

## Test plan
- Reset with RESET_PC = 32'h100, memory returning 32'hAAAA_0001, zero wait, D_stall = 0 -> addresses 0x100, 0x104, 0x108; F_pc_out4 = 0x104 on the first instruction; F_valid every 3rd cycle.
- D_stall held 5 cycles while in HOLD at pc 0x104 -> F_* stable for all 5 cycles; the next request (0x108) is issued only after D_stall drops.
- Redirect to 0x200 in WAIT with a 4-cycle response latency -> the stale response is discarded, F_valid stays 0, the next request is 0x200, and F_pc_out = 0x200.
- Redirect to 0x300 on the same cycle as rsp_valid -> the data is not presented and the next request is 0x300. A redirect in HOLD with D_stall = 0 -> the held instruction is dropped.
- Wrap: RESET_PC = 32'hFFFF_FFFC -> first F_pc_out4 = 0, second fetch address 0.
- With FETCH_MISALIGN_CHK_EN: redirect to 0x402 -> F_valid = 1, F_misalign = 1, F_instr = 0x0000_0013, F_pc_out = 0x402, and no imem request.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      HOLD,
      DROP
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response channel seen from the fetch stage.
interface fetch_if #(
   parameter int DATA_WIDTH = 32
) ();

   logic                  req_valid;
   logic                  req_ready;
   logic [DATA_WIDTH-1:0] addr;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_data;

   modport master (
      output req_valid, addr,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, addr,
      output req_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, one outstanding imem request, registered F_* outputs.
// Define FETCH_MISALIGN_CHK_EN to present misaligned redirects as a flagged NOP.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   fetch_if.master               imem,
   input  logic                  D_stall,
   input  logic                  redirect,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  F_valid,
   output logic [DATA_WIDTH-1:0] F_instr,
   output logic [DATA_WIDTH-1:0] F_pc_out,
   output logic [DATA_WIDTH-1:0] F_pc_out4
`ifdef FETCH_MISALIGN_CHK_EN
   ,
   output logic                  F_misalign
`endif
);

   localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(PC_STEP);

   fetch_state_t          state, state_d;
   logic [DATA_WIDTH-1:0] pc, pc_d, target;
   logic                  pend_mis, pend_d;
   logic                  bad_target;
   logic                  load_f, load_nop;

`ifdef FETCH_MISALIGN_CHK_EN
   assign target     = redirect_pc;
   assign bad_target = |redirect_pc[1:0];
   assign imem.addr  = pc;
`else
   localparam logic [DATA_WIDTH-1:0] WORD_MASK = ~DATA_WIDTH'(3);
   assign target     = redirect_pc & WORD_MASK;
   assign bad_target = 1'b0;
   assign imem.addr  = pc & WORD_MASK;
`endif

   assign imem.req_valid = rst && (state == REQ);

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d  = state;
      pc_d     = pc;
      pend_d   = pend_mis;
      load_f   = 1'b0;
      load_nop = 1'b0;
      unique case (state)
         REQ: begin
            if (redirect) begin
               pc_d = target;
               if (imem.req_ready) begin
                  state_d = DROP;
                  pend_d  = bad_target;
               end else if (bad_target) begin
                  state_d  = HOLD;
                  load_f   = 1'b1;
                  load_nop = 1'b1;
               end
            end else if (imem.req_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (redirect) begin
               pc_d = target;
               if (imem.rsp_valid) begin
                  state_d  = bad_target ? HOLD : REQ;
                  load_f   = bad_target;
                  load_nop = bad_target;
               end else begin
                  state_d = DROP;
                  pend_d  = bad_target;
               end
            end else if (imem.rsp_valid) begin
               state_d = HOLD;
               load_f  = 1'b1;
               pc_d    = pc + STEP;
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_d     = target;
               state_d  = bad_target ? HOLD : REQ;
               load_f   = bad_target;
               load_nop = bad_target;
            end else if (!D_stall) begin
               state_d = REQ;
            end
         end
         DROP: begin
            // A redirect here only retargets; the stale response is still owed.
            if (redirect) begin
               pc_d   = target;
               pend_d = bad_target;
            end
            if (imem.rsp_valid) begin
               pend_d   = 1'b0;
               load_nop = redirect ? bad_target : pend_mis;
               load_f   = load_nop;
               state_d  = load_nop ? HOLD : REQ;
            end
         end
         default: state_d = REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= REQ;
         pc        <= RESET_PC;
         pend_mis  <= 1'b0;
         F_valid   <= 1'b0;
         F_instr   <= '0;
         F_pc_out  <= '0;
         F_pc_out4 <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
         F_misalign <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state    <= state_d;
         pc       <= pc_d;
         pend_mis <= pend_d;
         F_valid  <= (state_d == HOLD);
         if (load_f) begin
            F_instr   <= load_nop ? DATA_WIDTH'(NOP_INSTR) : imem.rsp_data;
            F_pc_out  <= load_nop ? pc_d : pc;
            F_pc_out4 <= (load_nop ? pc_d : pc) + STEP;
         end
`ifdef FETCH_MISALIGN_CHK_EN
         if (load_f) begin
            F_misalign <= load_nop;
         end else if (state_d != HOLD) begin
            F_misalign <= 1'b0;
         end
`endif
      end
   end

endmodule
